// File: rtl/lb_pio_pkg.sv
// Register map and edge-type encodings shared by the HPS<->FPGA PIO blocks.
package lb_pio_pkg;
   localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
   localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
   localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/lb_pio_sync.sv
// Multi-flop input synchroniser with a one-cycle history register and edge detect.
module lb_pio_sync
   import lb_pio_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = EDGE_RISE
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [DATA_WIDTH-1:0] sync,
   output logic [DATA_WIDTH-1:0] edges
);
   logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] chain;
   logic [DATA_WIDTH-1:0]                  prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         chain <= '0;
         prev  <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], in_port};
         prev  <= chain[SYNC_STAGES-1];
      end
   end

   assign sync = chain[SYNC_STAGES-1];

   generate
      if (EDGE_TYPE == EDGE_RISE) begin : g_rise
         assign edges = sync & ~prev;
      end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
         assign edges = ~sync & prev;
      end else begin : g_any
         assign edges = sync ^ prev;
      end
   endgenerate
endmodule

// File: rtl/lb_to_hps_pio.sv
// Avalon-MM input PIO: live synchronised status, W1C edge capture and a maskable level IRQ.
module lb_to_hps_pio
   import lb_pio_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = EDGE_RISE
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic                  irq
);
   logic [DATA_WIDTH-1:0] sync, edges, irqmask, edgecap, clr;
   logic [31:0]           rmux;
   logic                  wr, rd;

   lb_pio_sync #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
   ) u_sync (
      .clk     (clk),
      .reset   (reset),
      .in_port (in_port),
      .sync    (sync),
      .edges   (edges)
   );

   assign wr  = chipselect & ~write_n;
   assign rd  = chipselect & write_n;
   assign clr = (wr && address == PIO_ADDR_EDGECAP) ? writedata[DATA_WIDTH-1:0] : '0;

   always_comb begin
      rmux = '0;
      case (address)
         PIO_ADDR_DATA:    rmux[DATA_WIDTH-1:0] = sync;
         PIO_ADDR_IRQMASK: rmux[DATA_WIDTH-1:0] = irqmask;
         PIO_ADDR_EDGECAP: rmux[DATA_WIDTH-1:0] = edgecap;
         default:          rmux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         irqmask  <= '0;
         edgecap  <= '0;
         irq      <= 1'b0;
         readdata <= '0;
      end else begin
         if (wr && address == PIO_ADDR_IRQMASK)
            irqmask <= writedata[DATA_WIDTH-1:0];
         // A fresh edge overrides a same-cycle clear so no event is lost.
         edgecap  <= (edgecap & ~clr) | edges;
         irq      <= |(edgecap & irqmask);
         readdata <= rd ? rmux : 32'd0;
      end
   end
endmodule

// File: tb/tb_lb_to_hps_pio.sv
// Directed bench for lb_to_hps_pio with hand-computed expectations (32 bits, 2 stages, rising edge).
module tb_lb_to_hps_pio;
   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [31:0] in_port;
   logic        irq;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lb_to_hps_pio #(.DATA_WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .irq        (irq)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      tick();
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b1; address = a;
      tick();
      d = readdata;
      chipselect = 1'b0;
   endtask

   logic [31:0] r;

   initial begin
      reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
      writedata = '0; in_port = '0;
      ticks(3);
      chk("rst_readdata", readdata, 32'h0);
      chk("rst_irq", {31'd0, irq}, 32'h0);
      reset = 1'b0;
      tick();
      for (int a = 0; a < 4; a++) begin
         bus_rd(a[1:0], r);
         chk($sformatf("rst_rd%0d", a), r, 32'h0);
      end

      // Data path: read issued at E0+1 sees old value, at E0+2 the new one
      in_port = 32'hA5A5_1234;
      tick();
      bus_rd(2'd0, r);
      chk("data_e0p1_old", r, 32'h0);
      bus_rd(2'd0, r);
      chk("data_e0p2_new", r, 32'hA5A5_1234);
      bus_wr(2'd1, 32'hFFFF_FFFF);
      bus_rd(2'd1, r);
      chk("rsvd_rd", r, 32'h0);
      bus_wr(2'd0, 32'h0);
      bus_rd(2'd0, r);
      chk("data_wr_ignored", r, 32'hA5A5_1234);
      bus_rd(2'd3, r);
      chk("cap_rising_bits", r, 32'hA5A5_1234);
      in_port = 32'h0;
      ticks(4);
      bus_rd(2'd3, r);
      chk("cap_no_fall", r, 32'hA5A5_1234);
      bus_wr(2'd3, 32'hFFFF_FFFF);
      bus_rd(2'd3, r);
      chk("cap_cleared", r, 32'h0);

      // Edge + IRQ on bit 0
      bus_wr(2'd2, 32'h1);
      bus_rd(2'd2, r);
      chk("mask_rd", r, 32'h1);
      in_port = 32'h1;
      ticks(3);
      chk("irq_e0p2_low", {31'd0, irq}, 32'h0);
      tick();
      chk("irq_e0p3_high", {31'd0, irq}, 32'h1);
      bus_rd(2'd3, r);
      chk("cap_bit0", r, 32'h1);
      bus_wr(2'd3, 32'h1);
      chk("irq_at_clr_edge", {31'd0, irq}, 32'h1);
      tick();
      chk("irq_after_clr", {31'd0, irq}, 32'h0);
      bus_rd(2'd3, r);
      chk("cap_bit0_clr", r, 32'h0);

      // Masking: bits 4 and 7, only bit 4 enabled
      bus_wr(2'd2, 32'h10);
      in_port = 32'h91;
      ticks(4);
      chk("mask_irq_high", {31'd0, irq}, 32'h1);
      bus_rd(2'd3, r);
      chk("mask_cap", r, 32'h90);
      bus_wr(2'd3, 32'h10);
      tick();
      chk("mask_irq_low", {31'd0, irq}, 32'h0);
      bus_rd(2'd3, r);
      chk("mask_cap_left", r, 32'h80);

      // Clear/edge collision on bit 3
      in_port = 32'h99;
      ticks(4);
      in_port = 32'h91;
      ticks(4);
      bus_rd(2'd3, r);
      chk("coll_pre", r, 32'h88);
      in_port = 32'h99;
      ticks(2);
      bus_wr(2'd3, 32'h8);
      bus_rd(2'd3, r);
      chk("coll_edge_wins", r, 32'h88);
      bus_wr(2'd3, 32'h8);
      bus_rd(2'd3, r);
      chk("coll_then_clr", r, 32'h80);

      // Reset mid-operation with a same-cycle IRQMASK write
      bus_wr(2'd2, 32'hFF);
      in_port = 32'h0;
      ticks(4);
      bus_wr(2'd3, 32'hFFFF_FFFF);
      in_port = 32'hFF;
      ticks(4);
      bus_rd(2'd3, r);
      chk("pre_rst_cap", r, 32'hFF);
      chk("pre_rst_irq", {31'd0, irq}, 32'h1);
      in_port = 32'h0;
      reset = 1'b1;
      chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'h0F;
      tick();
      chipselect = 1'b0; write_n = 1'b1; writedata = '0; reset = 1'b0;
      chk("midrst_irq", {31'd0, irq}, 32'h0);
      chk("midrst_readdata", readdata, 32'h0);
      tick();
      chk("midrst_irq_p1", {31'd0, irq}, 32'h0);
      bus_rd(2'd2, r);
      chk("midrst_mask", r, 32'h0);
      bus_rd(2'd3, r);
      chk("midrst_cap", r, 32'h0);
      bus_rd(2'd0, r);
      chk("midrst_data", r, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
